// File: rtl/sawtooth_ctrl_pkg.sv
// sawtooth_ctrl_pkg
//   Shared definitions for the sawtooth orbit controller: the FSM state
//   encoding and the default widths / datapath latency used by the top
//   and its countdown timer.
package sawtooth_ctrl_pkg;

    localparam int PRECISION_DEF   = 32;
    localparam int CNT_W_DEF       = 16;
    localparam int SAW_LATENCY_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_e;

    // Width of a down-counter that must hold the value lat-1.
    function automatic int lat_cnt_w(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/sawtooth_lat_timer.sv
// sawtooth_lat_timer
//   Load/decrement countdown used to wait out the sawtooth datapath latency.
//   Ports:
//     clk, reset_n  : clock, synchronous active-low reset (clears the count)
//     load_i        : load load_val_i (has priority over dec_i)
//     load_val_i    : value to load
//     dec_i         : decrement by one; saturates at zero
//     zero_o        : count is zero
module sawtooth_lat_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sawtooth_iter_ctrl.sv
// sawtooth_iter_ctrl
//   Drives an external fixed-latency sawtooth map unit to iterate
//   x <- saw(x, epsilon), discards n_warmup transient iterates and then
//   streams n_iter iterates out as keystream words with valid/ready.
//   Ports:
//     clk, reset_n          : clock, synchronous active-low reset
//     start                 : begin an orbit (only honoured in IDLE)
//     x0, epsilon           : seed and map parameter, latched on start
//     n_warmup, n_iter      : discarded / emitted iterate counts
//     busy                  : high outside IDLE
//     saw_tvalid, saw_x,
//     saw_epsilon           : request to the sawtooth unit
//     saw_result            : sawtooth output, valid SAW_LATENCY cycles
//                             after the edge that samples saw_tvalid
//     ks_valid, ks_ready,
//     ks_data, ks_last      : keystream output handshake
//     done                  : one-cycle pulse when the orbit completes
//   All outputs are registers, updated on the same edge as the state.
module sawtooth_iter_ctrl
    import sawtooth_ctrl_pkg::*;
#(
    parameter int PRECISION   = PRECISION_DEF,
    parameter int SAW_LATENCY = SAW_LATENCY_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PRECISION-1:0] x0,
    input  logic [PRECISION-1:0] epsilon,
    input  logic [CNT_W-1:0]     n_warmup,
    input  logic [CNT_W-1:0]     n_iter,
    output logic                 busy,
    output logic                 saw_tvalid,
    output logic [PRECISION-1:0] saw_x,
    output logic [PRECISION-1:0] saw_epsilon,
    input  logic [PRECISION-1:0] saw_result,
    output logic                 ks_valid,
    input  logic                 ks_ready,
    output logic [PRECISION-1:0] ks_data,
    output logic                 ks_last,
    output logic                 done
);

    localparam int TW = lat_cnt_w(SAW_LATENCY);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(SAW_LATENCY - 1);

    state_e               state_q;
    logic [PRECISION-1:0] x_q;
    logic [CNT_W-1:0]     warm_rem_q;
    logic [CNT_W-1:0]     iter_rem_q;
    logic                 busy_q;
    logic                 saw_tvalid_q;
    logic [PRECISION-1:0] saw_x_q;
    logic [PRECISION-1:0] saw_eps_q;
    logic                 ks_valid_q;
    logic [PRECISION-1:0] ks_data_q;
    logic                 ks_last_q;
    logic                 done_q;

    logic tmr_zero;

    // Loaded while leaving ISSUE, i.e. on the edge that hands saw_tvalid to
    // the datapath; it reads zero on the edge SAW_LATENCY cycles later.
    sawtooth_lat_timer #(
        .W (TW)
    ) u_lat_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (WAIT_LOAD),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            warm_rem_q   <= '0;
            iter_rem_q   <= '0;
            busy_q       <= 1'b0;
            saw_tvalid_q <= 1'b0;
            saw_x_q      <= '0;
            saw_eps_q    <= '0;
            ks_valid_q   <= 1'b0;
            ks_data_q    <= '0;
            ks_last_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q        <= x0;
                        saw_eps_q  <= epsilon;
                        warm_rem_q <= n_warmup;
                        iter_rem_q <= n_iter;
                        busy_q     <= 1'b1;
                        if (n_iter == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_ISSUE;
                            saw_tvalid_q <= 1'b1;
                            saw_x_q      <= x0;
                        end
                    end
                end

                ST_ISSUE: begin
                    saw_tvalid_q <= 1'b0;
                    state_q      <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (tmr_zero) begin
                        x_q <= saw_result;
                        if (warm_rem_q != '0) begin
                            // Transient iterate: feed straight back, never shown.
                            warm_rem_q   <= warm_rem_q - 1'b1;
                            state_q      <= ST_ISSUE;
                            saw_tvalid_q <= 1'b1;
                            saw_x_q      <= saw_result;
                        end else begin
                            state_q    <= ST_EMIT;
                            ks_valid_q <= 1'b1;
                            ks_data_q  <= saw_result;
                            ks_last_q  <= (iter_rem_q == CNT_W'(1));
                        end
                    end
                end

                ST_EMIT: begin
                    // Stall here; nothing is reissued until the word is taken.
                    if (ks_ready) begin
                        ks_valid_q <= 1'b0;
                        ks_last_q  <= 1'b0;
                        iter_rem_q <= iter_rem_q - 1'b1;
                        if (iter_rem_q == CNT_W'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_ISSUE;
                            saw_tvalid_q <= 1'b1;
                            saw_x_q      <= x_q;
                        end
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign saw_tvalid  = saw_tvalid_q;
    assign saw_x       = saw_x_q;
    assign saw_epsilon = saw_eps_q;
    assign ks_valid    = ks_valid_q;
    assign ks_data     = ks_data_q;
    assign ks_last     = ks_last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sawtooth_iter_ctrl.sv
module tb_sawtooth_iter_ctrl;

    localparam int P  = 32;
    localparam int L  = 24;
    localparam int CW = 16;
    localparam logic [31:0] EPS  = 32'h3d4ccccd;
    localparam logic [31:0] SEED = 32'h3fe00000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [P-1:0]  x0 = '0;
    logic [P-1:0]  epsilon = '0;
    logic [CW-1:0] n_warmup = '0;
    logic [CW-1:0] n_iter = '0;
    logic          busy;
    logic          saw_tvalid;
    logic [P-1:0]  saw_x;
    logic [P-1:0]  saw_epsilon;
    logic [P-1:0]  saw_result = '0;
    logic          ks_valid;
    logic          ks_ready = 1'b1;
    logic [P-1:0]  ks_data;
    logic          ks_last;
    logic          done;

    always #5 clk = ~clk;

    sawtooth_iter_ctrl #(
        .PRECISION   (P),
        .SAW_LATENCY (L),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .x0          (x0),
        .epsilon     (epsilon),
        .n_warmup    (n_warmup),
        .n_iter      (n_iter),
        .busy        (busy),
        .saw_tvalid  (saw_tvalid),
        .saw_x       (saw_x),
        .saw_epsilon (saw_epsilon),
        .saw_result  (saw_result),
        .ks_valid    (ks_valid),
        .ks_ready    (ks_ready),
        .ks_data     (ks_data),
        .ks_last     (ks_last),
        .done        (done)
    );

    // Edge counter: after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub sawtooth: result = x+1, presented so the edge L after the one that
    // samples tvalid picks it up; garbage until then, then held.
    logic [P-1:0] stub_x = '0;
    int           stub_at = 0;
    logic         stub_pend = 1'b0;
    always @(posedge clk) begin
        if (saw_tvalid) begin
            stub_x     <= saw_x;
            stub_at    <= cyc + L - 1;
            stub_pend  <= 1'b1;
            saw_result <= 32'hdeadbeef;
        end else if (stub_pend && cyc == stub_at) begin
            saw_result <= stub_x + 1;
            stub_pend  <= 1'b0;
        end
    end

    // Passive monitor, sampled mid-cycle.
    int           iss_edge [256];
    logic [P-1:0] words [64];
    logic         lasts [64];
    int n_iss = 0, n_w = 0, n_lat = 0, lat_bad = 0, eps_bad = 0, tv_ks = 0;
    int n_done = 0, done_edge = 0, hs_edge = 0, last_bad = 0, n_ksv = 0;
    logic mon_pend = 1'b0, p_tv = 1'b0, p_ksv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_pend = 1'b0;
        end else begin
            if (mon_pend && ((saw_tvalid && !p_tv) || (ks_valid && !p_ksv))) begin
                n_lat++;
                if (n_iss > 0 && cyc - iss_edge[n_iss-1] != L) lat_bad++;
                mon_pend = 1'b0;
            end
            if (saw_tvalid && n_iss < 256) begin
                iss_edge[n_iss] = cyc + 1;
                n_iss++;
                mon_pend = 1'b1;
                if (ks_valid) tv_ks++;
            end
            if (ks_valid) n_ksv++;
            if (ks_valid && ks_ready && n_w < 64) begin
                words[n_w] = ks_data;
                lasts[n_w] = ks_last;
                hs_edge    = cyc + 1;
                n_w++;
            end
            if (ks_last && !ks_valid) last_bad++;
            if (done) begin
                n_done++;
                done_edge = cyc + 1;
            end
            if (busy && saw_epsilon !== EPS) eps_bad++;
        end
        p_tv  = saw_tvalid;
        p_ksv = ks_valid;
    end

    int errs = 0, checks = 0;
    int s_w, s_iss, s_lat, s_latbad, s_eps, s_tvks, s_done, s_lastbad, s_ksv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_w = n_w; s_iss = n_iss; s_lat = n_lat; s_latbad = lat_bad; s_eps = eps_bad;
        s_tvks = tv_ks; s_done = n_done; s_lastbad = last_bad; s_ksv = n_ksv;
    endtask

    task automatic launch(input logic [31:0] xs, input int nw, input int ni);
        x0 = xs; epsilon = EPS; n_warmup = CW'(nw); n_iter = CW'(ni);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        step();
        step();
    endtask

    // Expected outcome of x0=SEED, n_warmup=2, n_iter=3.
    task automatic check_basic(input string tag, input bit chk_gap34);
        chk({tag, " nwords"}, 32'(n_w - s_w), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk({tag, " word"}, words[s_w + k], SEED + 32'(3 + k));
            chk({tag, " last"}, 32'(lasts[s_w + k]), (k == 2) ? 32'd1 : 32'd0);
        end
        chk({tag, " ntvalid"}, 32'(n_iss - s_iss), 32'd5);
        if (chk_gap34)
            chk({tag, " gap34"}, 32'(iss_edge[s_iss + 3] - iss_edge[s_iss + 2]), 32'(L + 2));
        chk({tag, " gap45"}, 32'(iss_edge[s_iss + 4] - iss_edge[s_iss + 3]), 32'(L + 2));
        chk({tag, " ncapt"}, 32'(n_lat - s_lat), 32'd5);
        chk({tag, " latency"}, 32'(lat_bad - s_latbad), 32'd0);
        chk({tag, " eps"}, 32'(eps_bad - s_eps), 32'd0);
        chk({tag, " tv_in_emit"}, 32'(tv_ks - s_tvks), 32'd0);
        chk({tag, " ndone"}, 32'(n_done - s_done), 32'd1);
        chk({tag, " done_lag"}, 32'(done_edge - hs_edge), 32'd1);
        chk({tag, " stray_last"}, 32'(last_bad - s_lastbad), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " tvalid"}, 32'(saw_tvalid), 32'd0);
        chk({tag, " ks_valid"}, 32'(ks_valid), 32'd0);
        chk({tag, " ks_last"}, 32'(ks_last), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " saw_x"}, saw_x, 32'd0);
        chk({tag, " saw_eps"}, saw_epsilon, 32'd0);
        chk({tag, " ks_data"}, ks_data, 32'd0);
    endtask

    initial begin
        int k;
        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_zero_outs("reset");
        step();
        reset_n = 1'b1;
        step();

        // Basic orbit
        snap();
        launch(SEED, 2, 3);
        wait_done("basic");
        check_basic("basic", 1'b1);

        // Zero iterations: done sampled high on the 2nd edge after start is driven
        snap();
        x0 = SEED; epsilon = EPS; n_warmup = 16'd2; n_iter = 16'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero done_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero done", 32'(done), 32'd1);
        @(negedge clk);
        chk("zero done_pulse", 32'(done), 32'd0);
        chk("zero busy", 32'(busy), 32'd0);
        step();
        chk("zero ntvalid", 32'(n_iss - s_iss), 32'd0);
        chk("zero nksv", 32'(n_ksv - s_ksv), 32'd0);
        step();

        // Backpressure during the first EMIT
        snap();
        ks_ready = 1'b0;
        launch(SEED, 2, 3);
        k = 0;
        while (!ks_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("bp reached_emit", 32'(ks_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp hold_valid", 32'(ks_valid), 32'd1);
            chk("bp hold_data", ks_data, SEED + 32'd3);
        end
        chk("bp no_issue", 32'(n_iss - s_iss), 32'd3);
        step();
        ks_ready = 1'b1;
        wait_done("bp");
        check_basic("bp", 1'b0);

        // start while busy is ignored
        snap();
        launch(SEED, 2, 3);
        repeat (30) step();
        x0 = 32'h42f63d71; n_warmup = 16'd0; n_iter = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("busy_start");
        check_basic("busy_start", 1'b1);

        // Reset in WAIT aborts the orbit
        snap();
        launch(SEED, 2, 3);
        k = 0;
        while (!saw_tvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check_zero_outs("midrst");
        repeat (80) step();
        chk("midrst ndone", 32'(n_done - s_done), 32'd0);
        chk("midrst nksv", 32'(n_ksv - s_ksv), 32'd0);
        snap();
        launch(SEED, 2, 3);
        wait_done("after_rst");
        check_basic("after_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
